// File: rtl/control_unit_if.sv
// Bundle between the multi-cycle control FSM and its datapath/memory.
// master = control unit side, slave = datapath side.
interface control_unit_if;
    logic [31:0] instr;
    logic        instrValid;
    logic        zero;
    logic        memReady;
    logic [5:0]  operation;
    logic [1:0]  ALUOp;
    logic        irWrite;
    logic        pcWrite;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  pcSrc;
    logic        halted;
    logic        trap;
    logic [31:0] instrCount;

    modport master (
        input  instr, instrValid, zero, memReady,
        output operation, ALUOp, irWrite, pcWrite, regWrite, memRead, memWrite,
               pcSrc, halted, trap, instrCount
    );

    modport slave (
        output instr, instrValid, zero, memReady,
        input  operation, ALUOp, irWrite, pcWrite, regWrite, memRead, memWrite,
               pcSrc, halted, trap, instrCount
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK plus absorbing HALT/TRAP.
// Define INSTR_COUNT_EN to build the retired-instruction counter; otherwise instrCount is tied to 0.
module control_unit (
    input logic            clock,
    input logic            reset,
    control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LDI   = 6'b000001;
    localparam logic [5:0] OP_LD    = 6'b000010;
    localparam logic [5:0] OP_ST    = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JMP   = 6'b000110;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;
    logic [5:0] funct_q, funct_d;

    logic       ir_write, pc_write, reg_write, mem_read, mem_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic [5:0] alu_sel;
    logic       halted, trap, retire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_src    = 2'b00;
        alu_op    = 2'b00;
        alu_sel   = 6'b000000;
        halted    = 1'b0;
        trap      = 1'b0;
        retire    = 1'b0;

        // ALU controls stay stable from EXECUTE through the end of the instruction
        if (state_q inside {S_EXECUTE, S_MEMORY, S_WRITEBACK}) begin
            case (opcode_q)
                OP_RTYPE: alu_sel = funct_q;
                OP_LDI:   alu_op  = 2'b01;
                OP_LD,
                OP_ST:    alu_op  = 2'b11;
                OP_BEQ:   alu_sel = 6'b000010;
                OP_BNE: begin
                    alu_op  = 2'b10;
                    alu_sel = 6'b000010;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                if (bus.instrValid) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    opcode_d = bus.instr[31:26];
                    funct_d  = bus.instr[5:0];
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode_q)
                    OP_RTYPE, OP_LDI, OP_LD, OP_ST, OP_BEQ, OP_BNE: state_d = S_EXECUTE;
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_TRAP;
                endcase
            end
            S_EXECUTE: begin
                case (opcode_q)
                    OP_RTYPE, OP_LDI: state_d = S_WRITEBACK;
                    OP_LD, OP_ST:     state_d = S_MEMORY;
                    OP_BEQ, OP_BNE: begin
                        // branch taken is decided by the ALU flag in this same cycle
                        if (bus.zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMORY: begin
                if (opcode_q == OP_LD) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                end
                if (bus.memReady) begin
                    if (opcode_q == OP_LD) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_TRAP:  trap   = 1'b1;
            default: state_d = S_TRAP;
        endcase
    end

    // Strobes are masked by reset so a Mealy FETCH strobe cannot leak while reset is held
    assign bus.irWrite   = ir_write  & ~reset;
    assign bus.pcWrite   = pc_write  & ~reset;
    assign bus.regWrite  = reg_write & ~reset;
    assign bus.memRead   = mem_read  & ~reset;
    assign bus.memWrite  = mem_write & ~reset;
    assign bus.pcSrc     = pc_src;
    assign bus.ALUOp     = alu_op;
    assign bus.operation = alu_sel;
    assign bus.halted    = halted;
    assign bus.trap      = trap;

`ifdef INSTR_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (retire) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.instrCount = count_q;
`else
    logic unused_retire;
    assign unused_retire  = retire;
    assign bus.instrCount = 32'd0;
`endif

    logic [19:0] unused_instr_mid;
    assign unused_instr_mid = bus.instr[25:6];
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe/ALU checks for each instruction class, reset and status.
module tb_control_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    control_unit_if bus();

    control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef INSTR_COUNT_EN
        return exp_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Present an instruction in FETCH, check the fetch strobes, advance into DECODE.
    task automatic fetch(input logic [31:0] ins, input string tag);
        bus.instr      = ins;
        bus.instrValid = 1'b1;
        #1;
        chk({tag, " irWrite"}, bus.irWrite, 1);
        chk({tag, " pcWrite"}, bus.pcWrite, 1);
        chk({tag, " pcSrc"},   bus.pcSrc,   0);
        tick();
        bus.instrValid = 1'b0;
        bus.instr      = 32'hFC00_0000;
    endtask

    initial begin
        bus.instr      = 32'h0;
        bus.instrValid = 1'b0;
        bus.zero       = 1'b0;
        bus.memReady   = 1'b0;

        // reset state
        #3;
        bus.instrValid = 1'b1;
        #1;
        chk("rst irWrite",    bus.irWrite,    0);
        chk("rst pcWrite",    bus.pcWrite,    0);
        chk("rst regWrite",   bus.regWrite,   0);
        chk("rst memRead",    bus.memRead,    0);
        chk("rst memWrite",   bus.memWrite,   0);
        chk("rst pcSrc",      bus.pcSrc,      0);
        chk("rst ALUOp",      bus.ALUOp,      0);
        chk("rst operation",  bus.operation,  0);
        chk("rst halted",     bus.halted,     0);
        chk("rst trap",       bus.trap,       0);
        chk("rst instrCount", bus.instrCount, 0);
        bus.instrValid = 1'b0;
        tick();
        reset = 1'b0;

        // R-type add
        fetch(32'h0000_0001, "radd");
        bus.instrValid = 1'b1;
        bus.instr      = 32'h0000_0003;
        #1;
        chk("radd dec irWrite", bus.irWrite, 0);
        chk("radd dec ALUOp",   bus.ALUOp,   0);
        chk("radd dec op",      bus.operation, 0);
        tick();
        bus.instrValid = 1'b0;
        #1;
        chk("radd exe ALUOp",    bus.ALUOp,     0);
        chk("radd exe op",       bus.operation, 1);
        chk("radd exe regWrite", bus.regWrite,  0);
        tick();
        #1;
        chk("radd wb regWrite", bus.regWrite,  1);
        chk("radd wb op",       bus.operation, 1);
        tick();
        exp_cnt++;
        #1;
        chk("radd fetch idle irWrite", bus.irWrite,  0);
        chk("radd fetch regWrite",     bus.regWrite, 0);
        chk("radd count",              bus.instrCount, cnt_exp());

        // BNE taken (zero=1)
        fetch({6'b000101, 26'h0}, "bne1");
        #1;
        chk("bne1 dec pcWrite", bus.pcWrite, 0);
        tick();
        bus.zero = 1'b1;
        #1;
        chk("bne1 exe pcWrite", bus.pcWrite,   1);
        chk("bne1 exe pcSrc",   bus.pcSrc,     1);
        chk("bne1 exe ALUOp",   bus.ALUOp,     2);
        chk("bne1 exe op",      bus.operation, 2);
        tick();
        bus.zero = 1'b0;
        exp_cnt++;

        // BNE not taken (zero=0)
        fetch({6'b000101, 26'h0}, "bne0");
        tick();
        #1;
        chk("bne0 exe pcWrite", bus.pcWrite, 0);
        chk("bne0 exe ALUOp",   bus.ALUOp,   2);
        tick();
        exp_cnt++;
        #1;
        chk("bne0 count", bus.instrCount, cnt_exp());

        // BEQ taken
        fetch({6'b000100, 26'h0}, "beq");
        tick();
        bus.zero = 1'b1;
        #1;
        chk("beq exe pcWrite", bus.pcWrite,   1);
        chk("beq exe pcSrc",   bus.pcSrc,     1);
        chk("beq exe ALUOp",   bus.ALUOp,     0);
        chk("beq exe op",      bus.operation, 2);
        tick();
        bus.zero = 1'b0;
        exp_cnt++;

        // LD with memReady low for three MEMORY cycles
        fetch({6'b000010, 26'h0}, "ld");
        bus.memReady = 1'b1;
        #1;
        chk("ld dec memRead", bus.memRead, 0);
        tick();
        bus.memReady = 1'b1;
        #1;
        chk("ld exe ALUOp",   bus.ALUOp,   3);
        chk("ld exe memRead", bus.memRead, 0);
        tick();
        bus.memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld mem wait memRead", bus.memRead,  1);
            chk("ld mem wait ALUOp",   bus.ALUOp,    3);
            chk("ld mem wait regWrite", bus.regWrite, 0);
            tick();
        end
        bus.memReady = 1'b1;
        #1;
        chk("ld mem last memRead", bus.memRead, 1);
        tick();
        bus.memReady = 1'b0;
        #1;
        chk("ld wb regWrite", bus.regWrite, 1);
        chk("ld wb memRead",  bus.memRead,  0);
        chk("ld wb ALUOp",    bus.ALUOp,    3);
        tick();
        exp_cnt++;
        #1;
        chk("ld after regWrite", bus.regWrite, 0);

        // JMP
        fetch({6'b000110, 26'h0}, "jmp");
        #1;
        chk("jmp dec pcWrite", bus.pcWrite, 1);
        chk("jmp dec pcSrc",   bus.pcSrc,   2);
        tick();
        exp_cnt++;
        #1;
        chk("jmp count", bus.instrCount, cnt_exp());

        // ST completing immediately
        fetch({6'b000011, 26'h0}, "st");
        tick();
        tick();
        bus.memReady = 1'b1;
        #1;
        chk("st mem memWrite", bus.memWrite, 1);
        chk("st mem memRead",  bus.memRead,  0);
        chk("st mem ALUOp",    bus.ALUOp,    3);
        tick();
        bus.memReady = 1'b0;
        exp_cnt++;
        #1;
        chk("st fetch memWrite", bus.memWrite, 0);
        chk("st count",          bus.instrCount, cnt_exp());

        // reset while ST waits in MEMORY
        fetch({6'b000011, 26'h0}, "strst");
        tick();
        tick();
        #1;
        chk("strst mem memWrite", bus.memWrite, 1);
        reset = 1'b1;
        #1;
        chk("strst async memWrite", bus.memWrite,   0);
        chk("strst instrCount",     bus.instrCount, 0);
        chk("strst ALUOp",          bus.ALUOp,      0);
        tick();
        reset   = 1'b0;
        exp_cnt = 0;

        // three R-types then HALT
        for (int k = 0; k < 3; k++) begin
            fetch({26'h0, 6'(k + 4)}, "r3");
            tick();
            #1;
            chk("r3 exe op", bus.operation, k + 4);
            tick();
            #1;
            chk("r3 wb regWrite", bus.regWrite, 1);
            tick();
            exp_cnt++;
        end
        fetch(32'hFC00_0000, "halt");
        #1;
        chk("halt dec halted", bus.halted, 0);
        tick();
        bus.instr      = 32'h0000_0001;
        bus.instrValid = 1'b1;
        #1;
        chk("halt halted",   bus.halted,     1);
        chk("halt irWrite",  bus.irWrite,    0);
        chk("halt pcWrite",  bus.pcWrite,    0);
        chk("halt count",    bus.instrCount, cnt_exp());
        tick();
        tick();
        #1;
        chk("halt stays halted", bus.halted,     1);
        chk("halt stays count",  bus.instrCount, cnt_exp());
        bus.instrValid = 1'b0;
        reset = 1'b1;
        #1;
        chk("halt rst halted", bus.halted, 0);
        tick();
        reset   = 1'b0;
        exp_cnt = 0;

        // unknown opcode 0x2A traps
        fetch({6'h2A, 26'h0}, "trap");
        #1;
        chk("trap dec trap", bus.trap, 0);
        tick();
        #1;
        chk("trap cycle3 trap", bus.trap, 1);
        for (int i = 0; i < 3; i++) begin
            bus.instr      = 32'h0000_0001;
            bus.instrValid = 1'b1;
            #1;
            chk("trap stays trap",    bus.trap,    1);
            chk("trap stays irWrite", bus.irWrite, 0);
            tick();
            bus.instrValid = 1'b0;
            tick();
        end
        chk("trap count", bus.instrCount, 0);
        reset = 1'b1;
        #1;
        chk("trap rst trap", bus.trap, 0);
        tick();
        reset = 1'b0;
        fetch(32'h0000_0001, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be as follows:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- instr  in  32  fetched instruction; opcode instr[31:26], funct instr[5:0]
- instrValid  in  1  instr valid this cycle
- zero  in  1  ALU zero/branch flag
- memReady  in  1  data memory access complete
- operation  out  6  ALU operation select
- ALUOp  out  2  ALU mode (00 funct, 01 pass imm, 10 BNE, 11 imm*4)
- irWrite, pcWrite, regWrite, memRead, memWrite  out  1 each  strobes
- pcSrc  out  2  00 PC+4, 01 branch target, 10 jump target
- halted, trap  out  1 each  status
- instrCount  out  32  retired-instruction count

Function
REQ-003 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, TRAP.
REQ-004 FETCH SHALL hold while instrValid=0; on instrValid=1 it SHALL assert irWrite, pcWrite (pcSrc=00) for one cycle, latch instr[31:26] and instr[5:0], and go to DECODE.
REQ-005 DECODE SHALL last one cycle and route by latched opcode:
- 000000 R-type, 000001 LDI, 000010 LD, 000011 ST, 000100 BEQ, 000101 BNE -> EXECUTE
- 000110 JMP -> assert pcWrite with pcSrc=10, then go to FETCH
- 111111 HALT -> HALT
- any other opcode -> TRAP
REQ-006 EXECUTE SHALL drive the ALU as follows:
- R-type: ALUOp=00, operation=latched funct
- LDI: ALUOp=01
- LD/ST: ALUOp=11
- BEQ: ALUOp=00, operation=000010
- BNE: ALUOp=10, operation=000010
REQ-007 BEQ/BNE in EXECUTE SHALL assert pcWrite with pcSrc=01 in that same cycle iff zero=1 (Mealy on zero), then go to FETCH.
REQ-008 R-type/LDI SHALL go EXECUTE -> WRITEBACK; LD/ST SHALL go EXECUTE -> MEMORY.
REQ-009 MEMORY SHALL hold memRead (LD) or memWrite (ST) high until memReady=1; then LD SHALL go to WRITEBACK and ST SHALL go to FETCH.
REQ-010 WRITEBACK SHALL assert regWrite for exactly one cycle, then go to FETCH.
REQ-011 In MEMORY and WRITEBACK, ALUOp/operation SHALL hold their EXECUTE values; in all other states they SHALL be 00/000000.
REQ-012 Minimum latencies, FETCH-entry to FETCH-entry with instrValid/memReady high: R-type/LDI 4, LD 5, ST 4, BEQ/BNE 3, JMP 2 cycles.
REQ-013 HALT and TRAP SHALL be absorbing until reset. halted=1 only in HALT; trap=1 only in TRAP. All strobes SHALL be 0 in both states.
REQ-014 instr and instrValid SHALL be ignored outside FETCH. memReady SHALL be ignored outside MEMORY.
REQ-015 Strobes other than those stated SHALL be 0 in every state.

Reset
REQ-016 Reset SHALL asynchronously force FETCH, clear latched opcode/funct, all strobes, pcSrc, ALUOp, operation, halted, trap and instrCount to 0.
REQ-017 Reset asserted mid-instruction (including in MEMORY with memRead/memWrite high) SHALL abort it with no further strobe asserted.
REQ-018 The first FETCH after reset deassertion SHALL be on the next rising edge.

Configuration
REQ-019 With macro INSTR_COUNT_EN defined, instrCount SHALL increment by 1, wrapping from 0xFFFFFFFF to 0, on every exit to FETCH from WRITEBACK, MEMORY (ST), EXECUTE (branch) or DECODE (JMP). HALT and TRAP SHALL not count.
REQ-020 Without INSTR_COUNT_EN, instrCount SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-021 Instr 0x00000001 (R-type add), instrValid=1 -> irWrite cycle 1; EXECUTE ALUOp=00, operation=000001; regWrite cycle 4; back in FETCH cycle 5.
REQ-022 BNE (opcode 000101) with zero=1 -> pcWrite=1, pcSrc=01, ALUOp=10 in cycle 3. Same instruction with zero=0 -> pcWrite=0 in cycle 3.
REQ-023 LD with memReady held low 3 cycles -> memRead high 4 cycles, ALUOp=11 throughout, then regWrite one cycle.
REQ-024 Opcode 0x2A -> trap=1 from cycle 3 onward and remains 1 with further instrValid pulses; reset clears trap.
REQ-025 Reset asserted during MEMORY of ST -> memWrite drops asynchronously, state FETCH, instrCount=0.
REQ-026 INSTR_COUNT_EN defined, 3 R-type then HALT -> instrCount=3, halted=1. Undefined -> instrCount=0.
